// File: rtl/vga_framebuffer_scan_if.sv
// Bundles the zoom control, result-RAM read port and VGA output of vga_framebuffer_scan.
// The master modport is the scanner side; the slave modport is the RAM/display side.
interface vga_framebuffer_scan_if;
    logic [1:0]  zoom_select;
    logic [7:0]  ram_data;
    logic [18:0] ram_addr;
    logic [7:0]  vga_r;
    logic [7:0]  vga_g;
    logic [7:0]  vga_b;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_blank_n;
    logic        vga_sync_n;
    logic        frame_start;

    modport master (
        input  zoom_select, ram_data,
        output ram_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
               frame_start
    );

    modport slave (
        output zoom_select, ram_data,
        input  ram_addr, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n,
               frame_start
    );
endinterface

// File: rtl/vga_framebuffer_scan.sv
// Scans the downscaled image out of the result RAM onto a VGA raster, centred on black.
// Optional IMG_BORDER_EN draws a one-pixel white ring around the image rectangle.
module vga_framebuffer_scan #(
    parameter int unsigned LARGURA_ORIG = 160,
    parameter int unsigned ALTURA_ORIG  = 120,
    parameter int unsigned CLK_DIV      = 2,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33
) (
    input  logic                         clk,
    input  logic                         rst,
    vga_framebuffer_scan_if.master       bus
);

    localparam logic [9:0] HAct       = 10'(H_ACTIVE);
    localparam logic [9:0] VAct       = 10'(V_ACTIVE);
    localparam logic [9:0] HSyncStart = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HSyncEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VSyncStart = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VSyncEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] HLast      = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] VLast      = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [1:0] DivLast    = 2'(CLK_DIV - 1);

    logic [1:0]  div_q, div_d;
    logic [9:0]  h_q, h_d, v_q, v_d;
    logic [1:0]  zoom_q, zoom_d;
    logic [18:0] ram_addr_q, ram_addr_d;
    logic        in_img_q, in_img_d;
    logic        active_q, active_d;
    logic        hs0_q, hs0_d, vs0_q, vs0_d;
    logic        fs0_q, fs0_d;
    logic        border0_q, border0_d;
    logic [7:0]  rgb_q, rgb_d;
    logic        hs_q, hs_d, vs_q, vs_d;
    logic        blank_n_q, blank_n_d;
    logic        frame_start_q, frame_start_d;

    logic        tick;
    logic [9:0]  img_w, img_h, x0, y0, x_end, y_end;
    logic        in_img;
    logic        border;
    logic [18:0] row, col, addr_calc;

    assign tick = (div_q == DivLast);

    // Geometry follows the latched zoom only, so it is constant across a frame.
    always_comb begin
        img_w     = 10'(LARGURA_ORIG) >> zoom_q;
        img_h     = 10'(ALTURA_ORIG) >> zoom_q;
        x0        = (HAct - img_w) >> 1;
        y0        = (VAct - img_h) >> 1;
        x_end     = x0 + img_w;
        y_end     = y0 + img_h;
        in_img    = (h_q >= x0) && (h_q < x_end) && (v_q >= y0) && (v_q < y_end);
        row       = 19'(v_q - y0);
        col       = 19'(h_q - x0);
        addr_calc = row * {9'd0, img_w} + col;
        border    = 1'b0;
`ifdef IMG_BORDER_EN
        border = (((h_q == x0 - 10'd1) || (h_q == x_end)) &&
                  (v_q >= y0 - 10'd1) && (v_q <= y_end)) ||
                 (((v_q == y0 - 10'd1) || (v_q == y_end)) &&
                  (h_q >= x0 - 10'd1) && (h_q <= x_end));
`endif
    end

    always_comb begin
        div_d         = tick ? 2'd0 : div_q + 2'd1;
        h_d           = h_q;
        v_d           = v_q;
        zoom_d        = zoom_q;
        ram_addr_d    = ram_addr_q;
        in_img_d      = in_img_q;
        active_d      = active_q;
        hs0_d         = hs0_q;
        vs0_d         = vs0_q;
        fs0_d         = fs0_q;
        border0_d     = border0_q;
        rgb_d         = rgb_q;
        hs_d          = hs_q;
        vs_d          = vs_q;
        blank_n_d     = blank_n_q;
        frame_start_d = 1'b0;

        if (tick) begin
            if (h_q == HLast) begin
                h_d = 10'd0;
                v_d = (v_q == VLast) ? 10'd0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
            if ((h_q == 10'd0) && (v_q == VAct)) begin
                zoom_d = bus.zoom_select;
            end

            // Stage 0: address and per-pixel flags for the current counter position.
            ram_addr_d = in_img ? addr_calc : 19'd0;
            in_img_d   = in_img;
            active_d   = (h_q < HAct) && (v_q < VAct);
            hs0_d      = !((h_q >= HSyncStart) && (h_q < HSyncEnd));
            vs0_d      = !((v_q >= VSyncStart) && (v_q < VSyncEnd));
            fs0_d      = (h_q == 10'd0) && (v_q == 10'd0);
            border0_d  = border;

            // Stage 1: RAM data has been valid since one clk after stage 0 issued the address.
            if (active_q && border0_q) begin
                rgb_d = 8'hFF;
            end else if (active_q && in_img_q) begin
                rgb_d = bus.ram_data;
            end else begin
                rgb_d = 8'h00;
            end
            hs_d          = hs0_q;
            vs_d          = vs0_q;
            blank_n_d     = active_q;
            frame_start_d = fs0_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q         <= 2'd0;
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            zoom_q        <= 2'd0;
            ram_addr_q    <= 19'd0;
            in_img_q      <= 1'b0;
            active_q      <= 1'b0;
            hs0_q         <= 1'b1;
            vs0_q         <= 1'b1;
            fs0_q         <= 1'b0;
            border0_q     <= 1'b0;
            rgb_q         <= 8'h00;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            zoom_q        <= zoom_d;
            ram_addr_q    <= ram_addr_d;
            in_img_q      <= in_img_d;
            active_q      <= active_d;
            hs0_q         <= hs0_d;
            vs0_q         <= vs0_d;
            fs0_q         <= fs0_d;
            border0_q     <= border0_d;
            rgb_q         <= rgb_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_n_q     <= blank_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.ram_addr    = ram_addr_q;
    assign bus.vga_r       = rgb_q;
    assign bus.vga_g       = rgb_q;
    assign bus.vga_b       = rgb_q;
    assign bus.vga_hs      = hs_q;
    assign bus.vga_vs      = vs_q;
    assign bus.vga_blank_n = blank_n_q;
    assign bus.vga_sync_n  = 1'b0;
    assign bus.frame_start = frame_start_q;

endmodule

// File: doc/vga_framebuffer_scan.md
Name: vga_framebuffer_scan

Overview:
- Downstream display stage for the block-average downscaler. Reads the downscaled grayscale image from the result RAM's read port and drives a 640x480@60 VGA output.
- Image is centred on a black background. Its size is 160/e x 120/e, where e is selected by zoom_select.
- Generates all sync/blank timing. Zoom changes are applied only at frame boundaries, so the displayed image never tears.

Parameters:
- LARGURA_ORIG, 160, source image width in pixels
- ALTURA_ORIG, 120, source image height in pixels
- CLK_DIV, 2, system clocks per pixel tick (50 MHz clk gives a 25 MHz pixel rate); legal values 2..4
- H_ACTIVE, 640 / H_FP 16 / H_SYNC 96 / H_BP 48, horizontal timing in pixels
- V_ACTIVE, 480 / V_FP 10 / V_SYNC 2 / V_BP 33, vertical timing in lines

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- zoom_select  in  2  00→e=1, 01→e=2, 10→e=4, 11→e=8 (same encoding as the downscaler)
- ram_data  in  8  RAM read data; valid exactly 1 clk after ram_addr
- ram_addr  out  19  RAM read address (registered)
- vga_r, vga_g, vga_b  out  8 each  grayscale replicated on all three channels
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vga_blank_n  out  1  high during the active 640x480 area
- vga_sync_n  out  1  tied 0
- frame_start  out  1  1-clk pulse on the tick where h=0, v=0 leaves the pipeline

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset values:
  - tick divider, h_cnt, v_cnt = 0
  - latched e = 1
  - ram_addr = 0
  - rgb = 0
  - vga_hs = 1, vga_vs = 1, vga_blank_n = 0, frame_start = 0
- Tick generation: a divider counts 0..CLK_DIV-1; tick = 1 when divider = CLK_DIV-1. All pipeline stages advance only on tick.
- Counters:
  - h_cnt runs 0..799.
  - At 799 it wraps to 0 and increments v_cnt; v_cnt runs 0..524 and wraps to 0.
- Stage 0 (counters → address), registered on tick:
  - img_w = LARGURA_ORIG/e, img_h = ALTURA_ORIG/e
  - x0 = (640-img_w)>>1, y0 = (480-img_h)>>1
  - in_img = (x0 ≤ h < x0+img_w) and (y0 ≤ v < y0+img_h)
  - ram_addr = (v-y0)*img_w + (h-x0) when in_img, else 0
  - in_img, active, hs and vs are also registered alongside.
- Stage 1 (data capture), on tick: rgb = ram_data if the delayed in_img and delayed active are both set, else 0. CLK_DIV ≥ 2 guarantees ram_data has settled by this tick.
- Alignment: sync, blank and frame_start are delayed by the same 2 ticks as pixel data, so every output refers to the same (h,v).
- Sync windows:
  - hs is low for h 656..751.
  - vs is low for v 490..491.
  - active when h < 640 and v < 480.
- Zoom latch:
  - zoom_select is sampled into e only on the tick where h=0 and v=480 (start of vertical blank).
  - Changes at any other time are ignored until that point; x0, y0, img_w and img_h are derived from the latched e.
- Arithmetic: the address product fits 19 bits (max 119*160+159 = 19199). Geometry values are computed in 10 bits with no truncation.
- Reset mid-frame: all outputs return to their reset values immediately. Scanning restarts at (0,0) with e=1 after reset deasserts.
- The block never writes the RAM. Reads while the downscaler is writing are permitted; torn pixels are acceptable.

Optional Feature:
- Macro: IMG_BORDER_EN.
- When defined:
  - The one-pixel ring just outside the image rectangle (x0-1 or x0+img_w in column, y0-1 or y0+img_h in row, limited to the rectangle's extent) outputs rgb = 8'hFF.
  - The border is pipelined identically to pixel data, so it stays aligned.
- When undefined: the ring is black, like the rest of the background.

Test Plan:
- Reset, e=1, run one frame:
  - first in-image ram_addr = 0 at h=240, v=180; last = 19199 at h=399, v=299.
  - rgb equals the RAM model's data 2 ticks after the counter position.
- Count hs and vs over a full frame:
  - 525 hs low pulses, each 96 ticks.
  - vs low for 2 lines starting at line 490.
  - 800*525 ticks per frame; frame_start exactly once per frame.
- zoom_select=11 latched:
  - image at x 310..329, y 232..246; ram_addr range 0..299.
  - background rgb = 0, vga_blank_n = 0 outside 640x480.
- Change zoom_select 00→01 mid-frame at v=100:
  - geometry unchanged for the rest of the frame.
  - next frame uses 80x60 at x0=280, y0=210.
- Assert rst during v=200, h=300:
  - outputs go immediately to their reset values.
  - after release, frame_start fires after 2 ticks with e=1.
- With IMG_BORDER_EN and e=2:
  - pixels at (279,209) and (360,270) are 8'hFF; (278,209) is 0.
  - without the macro, all three are 0.
